// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_pkg
// Description : Shared widths and entry record types for the reservation
//               station, dispatch and ROB.
// Revision    : 1.0  initial release
// ============================================================================
package rs_pkg;

    localparam int RS_DATA_WIDTH = 32;
    localparam int RS_TAG_WIDTH  = 4;
    localparam int RS_OP_WIDTH   = 4;

    typedef struct packed {
        logic                     rdy;
        logic [RS_TAG_WIDTH-1:0]  tag;
        logic [RS_DATA_WIDTH-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic                    valid;
        logic [RS_OP_WIDTH-1:0]  op;
        logic [RS_TAG_WIDTH-1:0] dest_tag;
        rs_src_t                 src1;
        rs_src_t                 src2;
    } rs_entry_t;

endpackage : rs_pkg
`default_nettype wire

// File: rtl/find_first_set.sv
`default_nettype none
// ============================================================================
// Module      : find_first_set
// Description : Priority encoder returning a found flag and the lowest set
//               bit index of a vector.
// Revision    : 1.0  initial release
// ============================================================================
module find_first_set #(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     vec,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] idx
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IDX_WIDTH'(i);
            end
        end
    end

endmodule : find_first_set
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : reservation_station
// Description : Per-FU micro-op buffer: holds ops until both operands arrive
//               from dispatch or the CDB, then issues via valid/ready.
// Revision    : 1.0  initial release
// ============================================================================
module reservation_station
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int DATA_WIDTH  = RS_DATA_WIDTH,
    parameter int TAG_WIDTH   = RS_TAG_WIDTH,
    parameter int OP_WIDTH    = RS_OP_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,

    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [OP_WIDTH-1:0]           disp_op,
    input  logic [TAG_WIDTH-1:0]          disp_dest_tag,
    input  logic                          disp_src1_rdy,
    input  logic                          disp_src2_rdy,
    input  logic [DATA_WIDTH-1:0]         disp_src1_val,
    input  logic [DATA_WIDTH-1:0]         disp_src2_val,
    input  logic [TAG_WIDTH-1:0]          disp_src1_tag,
    input  logic [TAG_WIDTH-1:0]          disp_src2_tag,

    input  logic                          cdb_valid,
    input  logic [TAG_WIDTH-1:0]          cdb_tag,
    input  logic [DATA_WIDTH-1:0]         cdb_data,

    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [OP_WIDTH-1:0]           issue_op,
    output logic [TAG_WIDTH-1:0]          issue_dest_tag,
    output logic [DATA_WIDTH-1:0]         issue_src1,
    output logic [DATA_WIDTH-1:0]         issue_src2,

    output logic [$clog2(NUM_ENTRIES):0]  occupancy
);

    localparam int c_IDX_WIDTH = $clog2(NUM_ENTRIES);
    localparam int c_CNT_WIDTH = c_IDX_WIDTH + 1;

    rs_entry_t                r_entries [NUM_ENTRIES];
    logic [c_CNT_WIDTH-1:0]   r_occ;
    logic                     r_lock_valid;
    logic [c_IDX_WIDTH-1:0]   r_lock_idx;

    logic [NUM_ENTRIES-1:0]   w_free;
    logic [NUM_ENTRIES-1:0]   w_elig;
    logic                     w_alloc_found;
    logic [c_IDX_WIDTH-1:0]   w_alloc_idx;
    logic                     w_elig_found;
    logic [c_IDX_WIDTH-1:0]   w_elig_idx;
    logic [c_IDX_WIDTH-1:0]   w_sel_idx;
    logic                     w_disp_fire;
    logic                     w_issue_fire;
    logic                     w_bypass1;
    logic                     w_bypass2;
    rs_entry_t                w_new_entry;

    always_comb begin
        w_free = '0;
        w_elig = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_free[i] = ~r_entries[i].valid;
            w_elig[i] = r_entries[i].valid & r_entries[i].src1.rdy & r_entries[i].src2.rdy;
        end
    end

    find_first_set #(
        .WIDTH     (NUM_ENTRIES),
        .IDX_WIDTH (c_IDX_WIDTH)
    ) u_alloc_ffs (
        .vec   (w_free),
        .found (w_alloc_found),
        .idx   (w_alloc_idx)
    );

    find_first_set #(
        .WIDTH     (NUM_ENTRIES),
        .IDX_WIDTH (c_IDX_WIDTH)
    ) u_issue_ffs (
        .vec   (w_elig),
        .found (w_elig_found),
        .idx   (w_elig_idx)
    );

    // A locked entry stays valid until accepted, so the lock alone implies issue_valid.
    assign w_sel_idx      = r_lock_valid ? r_lock_idx : w_elig_idx;
    assign issue_valid    = r_lock_valid | w_elig_found;
    assign issue_op       = r_entries[w_sel_idx].op;
    assign issue_dest_tag = r_entries[w_sel_idx].dest_tag;
    assign issue_src1     = r_entries[w_sel_idx].src1.val;
    assign issue_src2     = r_entries[w_sel_idx].src2.val;

    assign disp_ready   = (r_occ != c_CNT_WIDTH'(NUM_ENTRIES));
    assign occupancy    = r_occ;
    assign w_disp_fire  = disp_valid & disp_ready & w_alloc_found;
    assign w_issue_fire = issue_valid & issue_ready;

    assign w_bypass1 = cdb_valid & ~disp_src1_rdy & (disp_src1_tag == cdb_tag);
    assign w_bypass2 = cdb_valid & ~disp_src2_rdy & (disp_src2_tag == cdb_tag);

    always_comb begin
        w_new_entry           = '0;
        w_new_entry.valid     = 1'b1;
        w_new_entry.op        = disp_op;
        w_new_entry.dest_tag  = disp_dest_tag;
        w_new_entry.src1.rdy  = disp_src1_rdy | w_bypass1;
        w_new_entry.src1.tag  = disp_src1_tag;
        w_new_entry.src1.val  = w_bypass1 ? cdb_data : disp_src1_val;
        w_new_entry.src2.rdy  = disp_src2_rdy | w_bypass2;
        w_new_entry.src2.tag  = disp_src2_tag;
        w_new_entry.src2.val  = w_bypass2 ? cdb_data : disp_src2_val;
    end

    // Dispatch targets a free slot and wakeup only valid ones, so their writes never collide.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_entries[i].valid <= 1'b0;
            end
            r_occ        <= '0;
            r_lock_valid <= 1'b0;
            r_lock_idx   <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (r_entries[i].valid && cdb_valid) begin
                    if (!r_entries[i].src1.rdy && (r_entries[i].src1.tag == cdb_tag)) begin
                        r_entries[i].src1.rdy <= 1'b1;
                        r_entries[i].src1.val <= cdb_data;
                    end
                    if (!r_entries[i].src2.rdy && (r_entries[i].src2.tag == cdb_tag)) begin
                        r_entries[i].src2.rdy <= 1'b1;
                        r_entries[i].src2.val <= cdb_data;
                    end
                end
            end

            if (w_issue_fire) begin
                r_entries[w_sel_idx].valid <= 1'b0;
            end

            if (w_disp_fire) begin
                r_entries[w_alloc_idx] <= w_new_entry;
            end

            if (issue_valid && !issue_ready) begin
                r_lock_valid <= 1'b1;
                r_lock_idx   <= w_sel_idx;
            end else begin
                r_lock_valid <= 1'b0;
            end

            r_occ <= r_occ + c_CNT_WIDTH'(w_disp_fire) - c_CNT_WIDTH'(w_issue_fire);
        end
    end

endmodule : reservation_station
`default_nettype wire

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Per-functional-unit instruction buffer downstream of the dispatch demux.
- The demux routes a decoded micro-op to one station's dispatch port.
- The station holds the op until both source operands are available, capturing them from the common data bus (CDB) on a tag match.
- It then issues ready ops to its functional unit through a valid/ready handshake.

Parameters:
- NUM_ENTRIES, 4: number of buffered micro-ops; power of 2, ≥2.
- DATA_WIDTH, 32: operand and CDB data width.
- TAG_WIDTH, 4: ROB tag width, used for destination and source producer tags.
- OP_WIDTH, 4: functional-unit opcode width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all entries (mispredict recovery).
- disp_valid  in  1  dispatch micro-op present.
- disp_ready  out  1  station can accept a dispatch this cycle.
- disp_op  in  OP_WIDTH  opcode.
- disp_dest_tag  in  TAG_WIDTH  ROB tag of the result.
- disp_src1_rdy / disp_src2_rdy  in  1  operand value already valid.
- disp_src1_val / disp_src2_val  in  DATA_WIDTH  operand value; used when rdy=1.
- disp_src1_tag / disp_src2_tag  in  TAG_WIDTH  producer tag; used when rdy=0.
- cdb_valid  in  1  CDB broadcast present.
- cdb_tag  in  TAG_WIDTH  broadcast producer tag.
- cdb_data  in  DATA_WIDTH  broadcast result.
- issue_valid  out  1  a ready op is presented to the functional unit.
- issue_ready  in  1  functional unit accepts the op.
- issue_op  out  OP_WIDTH  opcode of the issued op.
- issue_dest_tag  out  TAG_WIDTH  destination tag of the issued op.
- issue_src1 / issue_src2  out  DATA_WIDTH  operand values of the issued op.
- occupancy  out  $clog2(NUM_ENTRIES)+1  count of valid entries (registered).

Behaviour:
- Per-entry state: valid, op, dest_tag, and for each of src1/src2 a rdy bit, tag, and val.
- Reset (rst=1) and flush:
  - Both clear every valid bit; occupancy=0, issue_valid=0, stall lock cleared.
  - All other storage is don't-care.
  - rst has priority over flush, and flush has priority over dispatch, CDB capture and issue in the same cycle.
- disp_ready = (occupancy != NUM_ENTRIES), derived from registered state only.
  - A slot freed by an issue in cycle t is reusable from cycle t+1.
- Dispatch (disp_valid & disp_ready):
  - Writes the lowest-index free entry at the edge.
  - Same-cycle bypass: if cdb_valid and cdb_tag matches a not-ready source tag, that source is written rdy=1 with val=cdb_data.
  - disp_valid while full is ignored; dispatch holds its inputs.
- Wakeup:
  - Every valid entry's not-ready source whose tag equals cdb_tag while cdb_valid=1 captures cdb_data and sets rdy=1.
  - Both sources of one entry may wake in the same cycle.
  - Already-ready sources are never overwritten.
- Eligibility: an entry is eligible when valid & src1.rdy & src2.rdy, evaluated on registered state.
  - Earliest issue is the cycle after dispatch.
  - An entry woken by the CDB in cycle t is eligible in t+1. There is no CDB-to-issue bypass.
- Selection:
  - When unlocked, the lowest-index eligible entry is selected.
  - issue_valid = an entry is selected; issue_* outputs are combinational from the selected entry.
- Stall lock:
  - If issue_valid=1 and issue_ready=0, the selected index is latched.
  - The same entry, with stable outputs, is presented every following cycle until issue_ready=1.
  - Newly eligible lower-index entries do not preempt it.
- Handshake:
  - issue_valid & issue_ready clears the entry's valid bit at the edge and releases the lock.
  - issue_ready while issue_valid=0 has no effect.
- Occupancy:
  - next = occupancy + dispatch_fire − issue_fire.
  - Simultaneous dispatch and issue leave the count unchanged.
- Tag uniqueness is guaranteed by the ROB; multiple entries waiting on one tag all wake together.

Decomposition:
- Package rs_pkg holds:
  - rs_src_t struct {rdy, tag, val};
  - rs_entry_t struct {valid, op, dest_tag, src1, src2};
  - the TAG_WIDTH/OP_WIDTH defaults shared with dispatch and the ROB.
- Sub-module find_first_set (parameter WIDTH) outputs a found flag and the lowest set index.
  - Instantiated twice: once on ~valid for free-slot allocation, once on the eligible vector for issue selection.

Test Plan:
- Reset → occupancy=0, issue_valid=0, disp_ready=1.
  - Dispatch op=3, dest=5, both rdy, src1=10, src2=20 → next cycle issue_valid=1, issue_op=3, dest=5, src1=10, src2=20; with issue_ready=1, occupancy returns to 0.
- Dispatch src1 waiting on tag 7, src2 ready → issue_valid stays 0.
  - CDB tag=7 data=0xAB → issue_valid=1 the following cycle with src1=0xAB.
- Dispatch with src tag 9 in the same cycle as CDB tag=9 data=0x55 → entry captures 0x55 (bypass); issues next cycle.
- Fill 4 entries, all waiting → disp_ready=0, occupancy=4; a 5th dispatch is ignored.
  - Wake entry 2 only → entry 2 issues; disp_ready=1 the cycle after.
- Entry 1 eligible, issue_ready=0 for 3 cycles; entry 0 wakes meanwhile → entry 1 stays presented with stable outputs; entry 0 issues after entry 1 is accepted.
- Occupancy=3, then assert flush together with a dispatch and a CDB match → next cycle occupancy=0, issue_valid=0, and the dispatch is dropped.
